// File: rtl/piso_pkg.sv
// Shared definitions for the PISO stream serializer: FSM encoding and counter sizing.
package piso_pkg;

    localparam logic [1:0] IDLE_ENC   = 2'd0;
    localparam logic [1:0] SHIFT_ENC  = 2'd1;
    localparam logic [1:0] PARITY_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE_ENC,
        ST_SHIFT  = SHIFT_ENC,
        ST_PARITY = PARITY_ENC
    } state_e;

    // clog2 that never returns zero, so single-value counters still get one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_stream_serializer_if.sv
// Upstream word handshake between the word source (master) and the serializer (slave).
interface piso_stream_serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/piso_bit_tick.sv
// Per-bit tick generator: counts down BIT_CYCLES-1..0, restarting on each accepted word.
module piso_bit_tick
    import piso_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic active,
    output logic tick_c,
    output logic last_tick_c
);
    localparam int unsigned TW = cnt_width(BIT_CYCLES);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = TW'(BIT_CYCLES - 1);
        end else if (active) begin
            cnt_d = (cnt_q == '0) ? TW'(BIT_CYCLES - 1) : cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick_c      = active;
    assign last_tick_c = active & (cnt_q == '0);
endmodule

// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out serializer for the TX path; streams words back-to-back.
// Optional even-parity bit after each word when PISO_PARITY_EN is defined.
module piso_stream_serializer
    import piso_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BIT_CYCLES = 1,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    piso_stream_serializer_if.slave          in_if,
    output logic                             ser_out,
    output logic                             ser_valid,
    output logic                             frame_start,
    output logic                             busy
);
    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

    state_e                state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  ser_out_q, ser_out_d;
    logic                  ser_valid_q, ser_valid_d;
    logic                  frame_start_q, frame_start_d;
`ifdef PISO_PARITY_EN
    logic                  parity_q, parity_d;
`endif
    logic tick_c, last_tick_c, bit_end_c, last_bit_c, in_ready_c, accept_c;

    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    piso_bit_tick #(.BIT_CYCLES(BIT_CYCLES)) u_bit_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart     (accept_c),
        .active      (state_q != ST_IDLE),
        .tick_c      (tick_c),
        .last_tick_c (last_tick_c)
    );

    assign bit_end_c  = tick_c & last_tick_c;
    assign last_bit_c = (bit_cnt_q == BW'(DATA_WIDTH - 1));
`ifdef PISO_PARITY_EN
    assign in_ready_c = (state_q == ST_IDLE) | ((state_q == ST_PARITY) & bit_end_c);
`else
    assign in_ready_c = (state_q == ST_IDLE) | ((state_q == ST_SHIFT) & last_bit_c & bit_end_c);
`endif
    assign accept_c       = in_if.in_valid & in_ready_c;
    assign in_if.in_ready = in_ready_c;

    // Next-state: advance bits on tick boundaries; an accept overrides the frame end
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        ser_out_d     = ser_out_q;
        ser_valid_d   = ser_valid_q;
        frame_start_d = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d      = parity_q;
`endif
        case (state_q)
            ST_SHIFT: begin
                if (bit_end_c) begin
                    if (!last_bit_c) begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        ser_out_d = head_bit(shreg_q);
                        shreg_d   = shift_word(shreg_q);
`ifdef PISO_PARITY_EN
                    end else begin
                        state_d   = ST_PARITY;
                        ser_out_d = parity_q;
                    end
`else
                    end else begin
                        state_d     = ST_IDLE;
                        bit_cnt_d   = '0;
                        ser_out_d   = IDLE_LEVEL;
                        ser_valid_d = 1'b0;
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (bit_end_c) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    ser_out_d   = IDLE_LEVEL;
                    ser_valid_d = 1'b0;
                end
            end
`endif
            default: ;
        endcase

        if (accept_c) begin
            state_d       = ST_SHIFT;
            bit_cnt_d     = '0;
            ser_out_d     = head_bit(in_if.in_data);
            shreg_d       = shift_word(in_if.in_data);
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
`ifdef PISO_PARITY_EN
            parity_d      = ^in_if.in_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            ser_out_q     <= IDLE_LEVEL;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
`ifdef PISO_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    // Shift register only changes on reload/shift; reset leaves it untouched
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = ser_valid_q;
endmodule

// File: tb/tb_piso_stream_serializer.sv
// Self-checking bench: two serializer configurations against a per-cycle queue model.
module tb_piso_stream_serializer;

`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = 8 + PAR;
    localparam int  BCS  [2] = '{1, 3};
    localparam bit  LSBF [2] = '{1'b0, 1'b1};
    localparam bit  IDL  [2] = '{1'b0, 1'b1};

    typedef struct packed { logic b; logic fs; } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ser_out [2], ser_valid [2], frame_start [2], busy [2];

    piso_stream_serializer_if #(.DATA_WIDTH(8)) if0 ();
    piso_stream_serializer_if #(.DATA_WIDTH(8)) if1 ();

    piso_stream_serializer #(.DATA_WIDTH(8), .BIT_CYCLES(1), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_if(if0.slave),
        .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .frame_start(frame_start[0]), .busy(busy[0]));

    piso_stream_serializer #(.DATA_WIDTH(8), .BIT_CYCLES(3), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_if(if1.slave),
        .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .frame_start(frame_start[1]), .busy(busy[1]));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted word expands into one queue entry per output clock
    ent_t mq [2][$];
    logic m_out [2], m_val [2], m_fs [2];

    task automatic model_step();
        logic v;
        logic [7:0] w;
        ent_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                mq[d].delete();
                m_out[d] = IDL[d]; m_val[d] = 1'b0; m_fs[d] = 1'b0;
            end else begin
                v = (d == 0) ? if0.in_valid : if1.in_valid;
                w = (d == 0) ? if0.in_data  : if1.in_data;
                if (v && mq[d].size() == 0) begin
                    for (int k = 0; k < 8; k++)
                        for (int c = 0; c < BCS[d]; c++) begin
                            e.b  = LSBF[d] ? w[k] : w[7-k];
                            e.fs = (k == 0 && c == 0);
                            mq[d].push_back(e);
                        end
                    for (int c = 0; c < BCS[d] * PAR; c++) begin
                        e.b = ^w; e.fs = 1'b0;
                        mq[d].push_back(e);
                    end
                end
                if (mq[d].size() != 0) begin
                    e = mq[d].pop_front();
                    m_out[d] = e.b; m_val[d] = 1'b1; m_fs[d] = e.fs;
                end else begin
                    m_out[d] = IDL[d]; m_val[d] = 1'b0; m_fs[d] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin m_out[d] = IDL[d]; m_val[d] = 1'b0; m_fs[d] = 1'b0; end
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("ser_out0",  32'(ser_out[0]),     32'(m_out[0]));
                chk("ser_valid0",32'(ser_valid[0]),   32'(m_val[0]));
                chk("fstart0",   32'(frame_start[0]), 32'(m_fs[0]));
                chk("busy0",     32'(busy[0]),        32'(m_val[0]));
                chk("in_ready0", 32'(if0.in_ready),   32'(mq[0].size() == 0));
                chk("ser_out1",  32'(ser_out[1]),     32'(m_out[1]));
                chk("ser_valid1",32'(ser_valid[1]),   32'(m_val[1]));
                chk("fstart1",   32'(frame_start[1]), 32'(m_fs[1]));
                chk("busy1",     32'(busy[1]),        32'(m_val[1]));
                chk("in_ready1", 32'(if1.in_ready),   32'(mq[1].size() == 0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic tick1();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] a, b;
        int cnt, ones, rdy, fsm;
        if0.in_valid = 1'b0; if0.in_data = '0;
        if1.in_valid = 1'b0; if1.in_data = '0;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ser_out0", 32'(ser_out[0]), 32'd0);
        chk("rst_ser_out1", 32'(ser_out[1]), 32'd1);
        chk("rst_valid0",   32'(ser_valid[0]), 32'd0);
        chk("rst_fs0",      32'(frame_start[0]), 32'd0);
        chk("rst_busy1",    32'(busy[1]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single word A5, MSB first
        tick1(); if0.in_valid = 1'b1; if0.in_data = 8'hA5;
        tick1(); if0.in_valid = 1'b0;
        fsm = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); a[7-i] = ser_out[0]; fsm += int'(frame_start[0]);
            if (i == 0) chk("a5_fs_first", 32'(frame_start[0]), 32'd1);
        end
        chk("a5_bits", 32'(a), 32'hA5);
        chk("a5_fs_count", 32'(fsm), 32'd1);
        repeat (PAR) @(negedge clk);
        @(negedge clk);
        chk("a5_idle_out", 32'(ser_out[0]), 32'd0);
        chk("a5_idle_valid", 32'(ser_valid[0]), 32'd0);

        // Back-to-back A5 then 3C
        tick1(); if0.in_valid = 1'b1; if0.in_data = 8'hA5;
        tick1(); if0.in_data = 8'h3C;
        cnt = 0; rdy = 0; fsm = 0;
        for (int i = 0; i < 2*FL; i++) begin
            @(negedge clk);
            if (i < 8) a[7-i] = ser_out[0];
            if (i >= FL && i < FL + 8) b[7-(i-FL)] = ser_out[0];
            cnt += int'(ser_valid[0]);
            if (i < 2*FL - 1) rdy += int'(if0.in_ready);
            if (frame_start[0]) fsm += i;
            if (i == FL - 1) chk("b2b_ready_last", 32'(if0.in_ready), 32'd1);
            if (i == FL) if0.in_valid = 1'b0;
        end
        chk("b2b_word0", 32'(a), 32'hA5);
        chk("b2b_word1", 32'(b), 32'h3C);
        chk("b2b_valid_count", 32'(cnt), 32'(2*FL));
        chk("b2b_ready_count", 32'(rdy), 32'd1);
        chk("b2b_fs_pos_sum", 32'(fsm), 32'(FL));
        @(negedge clk);
        chk("b2b_end_valid", 32'(ser_valid[0]), 32'd0);

        // LSB first, 3 clocks per bit, word 01
        tick1(); if1.in_valid = 1'b1; if1.in_data = 8'h01;
        tick1(); if1.in_valid = 1'b0;
        cnt = 0; ones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cnt += int'(busy[1]);
            if (busy[1]) ones += int'(ser_out[1]);
            if (i < 3) chk("lsb_first_ones", 32'(ser_out[1]), 32'd1);
            if (i == 3) chk("lsb_then_zero", 32'(ser_out[1]), 32'd0);
        end
        chk("lsb_busy_count", 32'(cnt), 32'(24 + 3*PAR));
        chk("lsb_ones_count", 32'(ones), 32'(3 + 3*PAR));
        chk("lsb_idle_level", 32'(ser_out[1]), 32'd1);

        // Asynchronous reset in the middle of FF, then clean 0F
        tick1(); if0.in_valid = 1'b1; if0.in_data = 8'hFF;
        tick1(); if0.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_ser_out", 32'(ser_out[0]), 32'd0);
        chk("arst_valid", 32'(ser_valid[0]), 32'd0);
        chk("arst_busy", 32'(busy[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick1(); if0.in_valid = 1'b1; if0.in_data = 8'h0F;
        tick1(); if0.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); a[7-i] = ser_out[0]; end
        chk("post_rst_0f", 32'(a), 32'h0F);
        repeat (PAR) @(negedge clk);
        @(negedge clk);
        chk("post_rst_idle", 32'(ser_valid[0]), 32'd0);

        // Parity bit (or its absence) after 07 and 03
        for (int t = 0; t < 2; t++) begin
            tick1(); if0.in_valid = 1'b1; if0.in_data = (t == 0) ? 8'h07 : 8'h03;
            tick1(); if0.in_valid = 1'b0;
            repeat (9) @(negedge clk);
`ifdef PISO_PARITY_EN
            chk("parity_valid", 32'(ser_valid[0]), 32'd1);
            chk("parity_bit", 32'(ser_out[0]), (t == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
`endif
            chk("frame_end_valid", 32'(ser_valid[0]), 32'd0);
        end

        // in_valid held while busy with changing data; only the ready cycle counts
        tick1(); if0.in_valid = 1'b1; if0.in_data = 8'hC3;
        tick1();
        for (int i = 0; i < 2*FL; i++) begin
            @(negedge clk);
            if (i < 8) a[7-i] = ser_out[0];
            if (i >= FL && i < FL + 8) b[7-(i-FL)] = ser_out[0];
            if (i < FL - 1) if0.in_data = 8'($urandom);
            else if (i == FL - 1) if0.in_data = 8'h5A;
            else if (i == FL) if0.in_valid = 1'b0;
        end
        chk("hold_word0", 32'(a), 32'hC3);
        chk("hold_word1", 32'(b), 32'h5A);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
